// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared types and constants for the mult_4 round-robin arbiter.
package mult_arb_pkg;

    localparam int OP_W         = 4;
    localparam int PP_W         = 8;
    localparam int TIMEOUT_DFLT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/mult_arb_if.sv
// mult_arb_if: requester-side and core-side signals of the mult_4 arbiter.
// master = environment (requesters + core), slave = the arbiter itself.
interface mult_arb_if #(
    parameter int N_REQ = 2
);
    import mult_arb_pkg::*;

    logic [N_REQ-1:0]      req;
    logic [OP_W*N_REQ-1:0] a;
    logic [OP_W*N_REQ-1:0] b;
    logic [N_REQ-1:0]      gnt;
    logic [N_REQ-1:0]      rsp_valid;
    logic [PP_W-1:0]       rsp_pp;
    logic                  rsp_err;
    logic [OP_W-1:0]       m_a;
    logic [OP_W-1:0]       m_b;
    logic                  m_init;
    logic                  m_done;
    logic [PP_W-1:0]       m_pp;

    modport master (
        output req, a, b, m_done, m_pp,
        input  gnt, rsp_valid, rsp_pp, rsp_err, m_a, m_b, m_init
    );

    modport slave (
        input  req, a, b, m_done, m_pp,
        output gnt, rsp_valid, rsp_pp, rsp_err, m_a, m_b, m_init
    );

endinterface

// File: rtl/mult_arb_rr_pick.sv
// rr_pick: combinational round-robin picker. Searches ptr, ptr+1, ... modulo N
// and returns the first requester with req high, one-hot and as an index.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [PW-1:0] win_idx
);

    logic [PW:0]   w_sum;
    logic [PW-1:0] w_idx;
    logic          w_found;

    // Walk the requesters in rotated order; first hit wins.
    always_comb begin
        win     = '0;
        win_idx = '0;
        w_sum   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_sum = {1'b0, ptr} + (PW+1)'(i);
            if (w_sum >= (PW+1)'(N)) begin
                w_sum = w_sum - (PW+1)'(N);
            end
            w_idx = w_sum[PW-1:0];
            if (!w_found && req[w_idx]) begin
                win[w_idx] = 1'b1;
                win_idx    = w_idx;
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_arb.sv
// mult_arb: shares one mult_4 core among N_REQ requesters with round-robin
// arbitration. Optional watchdog on the core's done: MULT_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for any req; picks winner from ptr
// ISSUE | one cycle: gnt[w] and m_init pulse, operands already on m_a/m_b
// WAIT  | waiting for a fresh rising edge of m_done (or watchdog expiry)
// RESP  | one cycle: rsp_valid[w] with product; ptr moves past w
module mult_arb
    import mult_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = TIMEOUT_DFLT
) (
    input logic       clk,
    input logic       rst,
    mult_arb_if.slave bus
);

    localparam int PW = $clog2(N_REQ);

    state_t           r_state;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_win_idx;
    logic [N_REQ-1:0] r_win;
    logic             r_done_q;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] r_rsp_valid;
    logic [PP_W-1:0]  r_rsp_pp;
    logic             r_m_init;
    logic [OP_W-1:0]  r_m_a;
    logic [OP_W-1:0]  r_m_b;

    logic [N_REQ-1:0] w_win;
    logic [PW-1:0]    w_win_idx;
    logic             w_done_rise;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0]  r_wd;
    logic             r_rsp_err;
`endif

    rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
        .req     (bus.req),
        .ptr     (r_ptr),
        .win     (w_win),
        .win_idx (w_win_idx)
    );

    // A done level left over from the previous operation must not count.
    assign w_done_rise = bus.m_done & ~r_done_q;

    // Arbitration / sequencing FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_win_idx   <= '0;
            r_win       <= '0;
            r_done_q    <= 1'b0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_pp    <= '0;
            r_m_init    <= 1'b0;
            r_m_a       <= '0;
            r_m_b       <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
            r_wd        <= '0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_done_q    <= bus.m_done;
            r_gnt       <= '0;
            r_m_init    <= 1'b0;
            r_rsp_valid <= '0;
            case (r_state)
                IDLE: begin
                    if (|bus.req) begin
                        r_state   <= ISSUE;
                        r_win     <= w_win;
                        r_win_idx <= w_win_idx;
                        r_gnt     <= w_win;
                        r_m_init  <= 1'b1;
                        r_m_a     <= bus.a[int'(w_win_idx)*OP_W +: OP_W];
                        r_m_b     <= bus.b[int'(w_win_idx)*OP_W +: OP_W];
                    end
                end
                ISSUE: begin
                    r_state <= WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
                    r_wd    <= '0;
`endif
                end
                WAIT: begin
                    if (w_done_rise) begin
                        r_state     <= RESP;
                        r_rsp_valid <= r_win;
                        r_rsp_pp    <= bus.m_pp;
`ifdef MULT_ARB_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
                    end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
                        r_state     <= RESP;
                        r_rsp_valid <= r_win;
                        r_rsp_pp    <= '0;
                        r_rsp_err   <= 1'b1;
                    end else begin
                        r_wd <= r_wd + 1'b1;
`endif
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    if (r_win_idx == PW'(N_REQ - 1)) begin
                        r_ptr <= '0;
                    end else begin
                        r_ptr <= r_win_idx + 1'b1;
                    end
`ifdef MULT_ARB_TIMEOUT_EN
                    r_rsp_err <= 1'b0;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_pp    = r_rsp_pp;
    assign bus.m_a       = r_m_a;
    assign bus.m_b       = r_m_b;
    assign bus.m_init    = r_m_init;
`ifdef MULT_ARB_TIMEOUT_EN
    assign bus.rsp_err   = r_rsp_err;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mult_arb.sv
// tb_mult_arb: self-checking bench for mult_arb with a behavioural mult_4 model.
module tb_mult_arb;

    localparam int N = 2;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   m_ptr    = 0;
    int   core_dly = 3;
    bit   core_sticky = 0;
    bit   core_never  = 0;

    mult_arb_if #(.N_REQ(N)) bus ();

    mult_arb #(.N_REQ(N), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Core model: done rises core_dly cycles after init (after first dropping
    // a stale done 2 cycles after init), held one cycle unless sticky.
    initial begin : core_model
        logic [7:0] pp;
        bus.m_done = 1'b0;
        bus.m_pp   = '0;
        forever begin
            @(negedge clk);
            if (bus.m_init === 1'b1 && !core_never) begin
                pp = bus.m_a * bus.m_b;
                if (bus.m_done) begin
                    repeat (2) @(negedge clk);
                    bus.m_done = 1'b0;
                end
                repeat (core_dly) @(negedge clk);
                bus.m_done = 1'b1;
                bus.m_pp   = pp;
                if (!core_sticky) begin
                    @(negedge clk);
                    bus.m_done = 1'b0;
                end
            end
        end
    end

    // Reference: first requester at or after ptr (modulo N) with req high.
    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req = '0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
    endtask

    task automatic wait_gnt(input int max_cyc, output int n);
        n = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (bus.gnt != '0) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic wait_rsp(input int max_cyc, output int n);
        n = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (bus.rsp_valid != '0) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.gnt !== '0 || bus.rsp_valid !== '0 || bus.m_init !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: gnt=%b rsp_valid=%b m_init=%b want 0", bus.gnt, bus.rsp_valid, bus.m_init);
        end
        checks++;
        if (bus.rsp_pp !== '0 || bus.rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_rsp: rsp_pp=%0d rsp_err=%b want 0", bus.rsp_pp, bus.rsp_err);
        end
        checks++;
        if (bus.m_a !== '0 || bus.m_b !== '0) begin
            failures++;
            $display("FAIL reset_ops: m_a=%0d m_b=%0d want 0", bus.m_a, bus.m_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int n;
        apply_reset();
        core_dly = 3;
        bus.req = 2'b01;
        bus.a = 8'h03;
        bus.b = 8'h05;
        wait_gnt(10, n);
        checks++;
        if (n !== 1 || bus.gnt !== 2'b01 || bus.m_init !== 1'b1) begin
            failures++;
            $display("FAIL single_gnt: lat=%0d gnt=%b init=%b want 1/01/1", n, bus.gnt, bus.m_init);
        end
        checks++;
        if (bus.m_a !== 4'd3 || bus.m_b !== 4'd5) begin
            failures++;
            $display("FAIL single_ops: m_a=%0d m_b=%0d want 3/5", bus.m_a, bus.m_b);
        end
        bus.req = '0;
        bus.a = 8'hFF;
        bus.b = 8'hFF;
        @(negedge clk);
        checks++;
        if (bus.gnt !== '0 || bus.m_init !== 1'b0 || bus.m_a !== 4'd3) begin
            failures++;
            $display("FAIL single_pulse: gnt=%b init=%b m_a=%0d want 00/0/3", bus.gnt, bus.m_init, bus.m_a);
        end
        wait_rsp(40, n);
        checks++;
        if (n !== 3) begin
            failures++;
            $display("FAIL single_rsp_latency: got %0d want 3 (4 after gnt)", n);
        end
        checks++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_pp !== 8'd15 || bus.rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL single_rsp: valid=%b pp=%0d err=%b want 01/15/0", bus.rsp_valid, bus.rsp_pp, bus.rsp_err);
        end
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== '0) begin
            failures++;
            $display("FAIL single_rsp_pulse: valid=%b want 00", bus.rsp_valid);
        end
    endtask

    task automatic test_contention();
        int n;
        int exp;
        int d;
        logic [7:0] exp_pp;
        apply_reset();
        bus.req = 2'b11;
        bus.a = 8'h2F;
        bus.b = 8'h7F;
        for (int op = 0; op < 4; op++) begin
            d = $urandom_range(1, 4);
            core_dly = d;
            exp = model_pick(bus.req, m_ptr);
            exp_pp = bus.a[exp*4 +: 4] * bus.b[exp*4 +: 4];
            wait_gnt(10, n);
            checks++;
            if (n !== (op == 0 ? 1 : 2) || bus.gnt !== N'(1 << exp)) begin
                failures++;
                $display("FAIL contention_gnt op%0d: lat=%0d gnt=%b want lat %0d gnt idx %0d", op, n, bus.gnt, (op == 0 ? 1 : 2), exp);
            end
            wait_rsp(40, n);
            checks++;
            if (n !== d + 1 || bus.rsp_valid !== N'(1 << exp) || bus.rsp_pp !== exp_pp) begin
                failures++;
                $display("FAIL contention_rsp op%0d: lat=%0d valid=%b pp=%0d want %0d/idx %0d/%0d", op, n, bus.rsp_valid, bus.rsp_pp, d + 1, exp, exp_pp);
            end
            m_ptr = (exp + 1) % N;
        end
        bus.req = '0;
    endtask

    task automatic test_random();
        int n;
        int exp;
        int d;
        logic [N-1:0] r;
        logic [7:0] av;
        logic [7:0] bv;
        logic [7:0] exp_pp;
        apply_reset();
        for (int op = 0; op < 24; op++) begin
            r  = N'($urandom_range(1, (1 << N) - 1));
            av = 8'($urandom);
            bv = 8'($urandom);
            d  = $urandom_range(1, 6);
            core_dly = d;
            bus.req = r;
            bus.a = av;
            bus.b = bv;
            exp = model_pick(r, m_ptr);
            exp_pp = av[exp*4 +: 4] * bv[exp*4 +: 4];
            wait_gnt(10, n);
            checks++;
            if (n !== (op == 0 ? 1 : 2) || bus.gnt !== N'(1 << exp) || bus.m_init !== 1'b1) begin
                failures++;
                $display("FAIL random_gnt op%0d: lat=%0d gnt=%b req=%b want idx %0d", op, n, bus.gnt, r, exp);
            end
            checks++;
            if (bus.m_a !== av[exp*4 +: 4] || bus.m_b !== bv[exp*4 +: 4]) begin
                failures++;
                $display("FAIL random_ops op%0d: m_a=%0d m_b=%0d want %0d/%0d", op, bus.m_a, bus.m_b, av[exp*4 +: 4], bv[exp*4 +: 4]);
            end
            bus.req = N'($urandom);
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            wait_rsp(40, n);
            checks++;
            if (n !== d + 1 || bus.rsp_valid !== N'(1 << exp) || bus.rsp_pp !== exp_pp || bus.rsp_err !== 1'b0) begin
                failures++;
                $display("FAIL random_rsp op%0d: lat=%0d valid=%b pp=%0d err=%b want %0d/idx %0d/%0d/0", op, n, bus.rsp_valid, bus.rsp_pp, bus.rsp_err, d + 1, exp, exp_pp);
            end
            m_ptr = (exp + 1) % N;
        end
        bus.req = '0;
    endtask

    task automatic test_stale_done();
        int n;
        apply_reset();
        core_sticky = 1;
        core_dly = 2;
        bus.req = 2'b01;
        bus.a = 8'h04;
        bus.b = 8'h06;
        wait_gnt(10, n);
        bus.req = '0;
        wait_rsp(40, n);
        checks++;
        if (n !== 3 || bus.rsp_pp !== 8'd24) begin
            failures++;
            $display("FAIL stale_first: lat=%0d pp=%0d want 3/24", n, bus.rsp_pp);
        end
        core_sticky = 0;
        bus.req = 2'b10;
        bus.a = 8'h90;
        bus.b = 8'h30;
        wait_gnt(10, n);
        bus.req = '0;
        checks++;
        if (n !== 2 || bus.gnt !== 2'b10 || bus.m_done !== 1'b1) begin
            failures++;
            $display("FAIL stale_gnt: lat=%0d gnt=%b done=%b want 2/10/1", n, bus.gnt, bus.m_done);
        end
        wait_rsp(40, n);
        checks++;
        if (n !== 5 || bus.rsp_valid !== 2'b10 || bus.rsp_pp !== 8'd27) begin
            failures++;
            $display("FAIL stale_rsp: lat=%0d valid=%b pp=%0d want 5/10/27", n, bus.rsp_valid, bus.rsp_pp);
        end
    endtask

    task automatic test_reset_mid_wait();
        int n;
        bit seen;
        apply_reset();
        core_dly = 2;
        bus.req = 2'b01;
        bus.a = 8'h01;
        bus.b = 8'h01;
        wait_gnt(10, n);
        bus.req = '0;
        wait_rsp(40, n);
        core_dly = 6;
        bus.req = 2'b10;
        bus.a = 8'h50;
        bus.b = 8'h50;
        wait_gnt(10, n);
        bus.req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.gnt !== '0 || bus.rsp_valid !== '0 || bus.rsp_pp !== '0 || bus.m_init !== 1'b0) begin
            failures++;
            $display("FAIL midrst_ctrl: gnt=%b valid=%b pp=%0d init=%b want 0", bus.gnt, bus.rsp_valid, bus.rsp_pp, bus.m_init);
        end
        checks++;
        if (bus.m_a !== '0 || bus.m_b !== '0) begin
            failures++;
            $display("FAIL midrst_ops: m_a=%0d m_b=%0d want 0", bus.m_a, bus.m_b);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.rsp_valid != '0 || bus.gnt != '0) seen = 1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL midrst_quiet: activity seen=%0d want 0", seen);
        end
        m_ptr = 0;
        core_dly = 2;
        bus.req = 2'b11;
        bus.a = 8'h21;
        bus.b = 8'h43;
        wait_gnt(10, n);
        bus.req = '0;
        checks++;
        if (n !== 1 || bus.gnt !== N'(1 << model_pick(2'b11, m_ptr))) begin
            failures++;
            $display("FAIL midrst_ptr: lat=%0d gnt=%b want 1/01", n, bus.gnt);
        end
        wait_rsp(40, n);
        checks++;
        if (n !== 3 || bus.rsp_pp !== 8'd3) begin
            failures++;
            $display("FAIL midrst_rsp: lat=%0d pp=%0d want 3/3", n, bus.rsp_pp);
        end
    endtask

    task automatic test_withdraw();
        int n;
        int rsp_at;
        bit seen_g1;
        apply_reset();
        core_dly = 5;
        bus.req = 2'b01;
        bus.a = 8'h07;
        bus.b = 8'h06;
        wait_gnt(10, n);
        bus.req = '0;
        seen_g1 = 0;
        rsp_at = -1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (bus.gnt[1]) seen_g1 = 1;
            if (bus.rsp_valid == 2'b01 && bus.rsp_pp == 8'd42) rsp_at = i;
            if (i == 2) bus.req = 2'b10;
            if (i == 4) bus.req = '0;
        end
        checks++;
        if (seen_g1) begin
            failures++;
            $display("FAIL withdraw_gnt: gnt[1] seen=%0d want 0", seen_g1);
        end
        checks++;
        if (rsp_at !== 6) begin
            failures++;
            $display("FAIL withdraw_rsp: rsp at %0d want 6", rsp_at);
        end
    endtask

`ifdef MULT_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        apply_reset();
        core_never = 1;
        bus.req = 2'b01;
        bus.a = 8'h09;
        bus.b = 8'h09;
        wait_gnt(10, n);
        bus.req = '0;
        wait_rsp(40, n);
        checks++;
        if (n !== 9 || bus.rsp_valid !== 2'b01 || bus.rsp_err !== 1'b1 || bus.rsp_pp !== '0) begin
            failures++;
            $display("FAIL timeout_rsp: lat=%0d valid=%b err=%b pp=%0d want 9/01/1/0", n, bus.rsp_valid, bus.rsp_err, bus.rsp_pp);
        end
        core_never = 0;
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.req = '0;
        bus.a = '0;
        bus.b = '0;
        test_reset();
        test_single();
        test_contention();
        test_stale_done();
        test_reset_mid_wait();
        test_withdraw();
`ifdef MULT_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_arb.md
# mult_arb

Round-robin arbiter and sequencer that shares one 4x4 `mult_4` multiplier core among `N_REQ` requesters. It accepts operand pairs, grants one requester at a time, pulses the core's `init`, waits for `done`, and returns the 8-bit product with a per-requester valid pulse. It sits between the requester logic and the single `mult_4` instance in the top-level wrapper.

## Interface

Parameters:
- `N_REQ`, 2: number of requesters (2..4).
- `TIMEOUT`, 32: cycles to wait for `m_done` before aborting. Used only when `MULT_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req` in N_REQ: request per requester, level-sensitive.
- `a` in 4*N_REQ: operand A, one nibble per requester. Requester i uses bits [4i+3:4i].
- `b` in 4*N_REQ: operand B, packed the same way as `a`.
- `gnt` out N_REQ: one-hot, one-cycle grant pulse.
- `rsp_valid` out N_REQ: one-hot, one-cycle result pulse.
- `rsp_pp` out 8: product. Valid only while any `rsp_valid` bit is high.
- `rsp_err` out 1: abort flag, qualified by `rsp_valid`. Tied to 0 without the macro.
- `m_a` out 4: operand A to the core.
- `m_b` out 4: operand B to the core.
- `m_init` out 1: start pulse to the core.
- `m_done` in 1: completion from the core.
- `m_pp` in 8: product from the core.

## Operation

State machine with four states:
- **IDLE**
  - If any `req` bit is high, select the winner with the round-robin rule and go to ISSUE.
  - If no `req` bit is high, stay in IDLE.
- **ISSUE** (exactly 1 cycle)
  - `gnt[w]`=1 and `m_init`=1.
  - `m_a` and `m_b` are taken from requester w's slice of `a` and `b`, registered at the IDLE→ISSUE edge.
  - Go to WAIT.
- **WAIT**
  - Exit on a rising edge of `m_done`, detected as `m_done & ~done_q`, where `done_q` is `m_done` registered one cycle.
  - A level-high `m_done` left over from the previous operation is ignored.
  - On the rising edge: capture `m_pp` into the result register and go to RESP.
- **RESP** (exactly 1 cycle)
  - `rsp_valid[w]`=1, `rsp_pp` = captured product, `rsp_err`=0.
  - Go to IDLE.

Round-robin rule:
- A pointer `ptr` is reset to 0.
- Search order is `ptr`, `ptr+1`, … modulo `N_REQ`. The first requester with `req` high wins.
- After RESP, `ptr` = w+1 modulo `N_REQ`, with wrap-around from `N_REQ-1` to 0.

Requester rules:
- Hold `req`, `a` and `b` stable until `gnt` is seen.
- Operands are consumed at grant. Changes to them after `gnt` have no effect.
- Dropping `req` before grant withdraws the request with no side effects.
- A requester may raise `req` again immediately after `gnt`. It is considered at the next IDLE.

Arithmetic: `rsp_pp` is the unsigned 8-bit product `m_pp` passed through unchanged; there is no overflow.

## Timing

Reset values:
- All outputs are 0.
- `ptr` = 0, state = IDLE, `done_q` = 0, `m_a` = `m_b` = 0.

Latency, with `req` sampled high in IDLE at cycle 0:
- `gnt` and `m_init` are high in cycle 1.
- If the `m_done` rising edge is sampled in cycle k, `rsp_valid` is high in cycle k+1.
- Back-to-back throughput is one operation per (k+2) cycles. IDLE lasts at least one cycle between operations.

Boundary conditions:
- Several `req` bits high in the same cycle: resolved by `ptr`.
- `req` arriving during ISSUE, WAIT or RESP: queued by level only; nothing is latched.
- Reset asserted mid-operation: immediate return to the reset values. The core is not re-initialised; any later `m_done` edge arriving in IDLE is ignored.
- `m_done` already high when WAIT is entered: no exit until it falls and rises again.

## Configuration

`MULT_ARB_TIMEOUT_EN`:
- Defined:
  - A watchdog counter is cleared in ISSUE and increments each WAIT cycle.
  - When it reaches `TIMEOUT` with no `m_done` edge, go to RESP with `rsp_err`=1 and `rsp_pp`=0.
  - `ptr` advances as normal.
- Undefined:
  - No counter exists; WAIT can last indefinitely.
  - `rsp_err` is tied to 0.

## Structure

- Package `mult_arb_pkg`:
  - state enum `{IDLE, ISSUE, WAIT, RESP}`
  - `OP_W`=4, `PP_W`=8
  - default `TIMEOUT_DFLT`=32
- One sub-module `rr_pick`:
  - Combinational round-robin picker with inputs `req` and `ptr`, outputs a one-hot `win` and the binary `win_idx`.
  - Reusable by other arbiters sharing this core.

## Test plan

- **Single request.** After reset, `req`=01, `a`[3:0]=3, `b`[3:0]=5; model returns done 3 cycles after init. Expect `gnt`=01 and `m_init` in cycle 1, `m_a`=3, `m_b`=5, then `rsp_valid`=01 with `rsp_pp`=15.
- **Contention.** `req`=11 held with requester 0 = 15×15 and requester 1 = 2×7. Expect requester 0 served first with `rsp_pp`=225, then requester 1 with `rsp_pp`=14, then requester 0 again: strict alternation.
- **Stale done.** Model keeps `m_done` high after the previous result and drops it 2 cycles after the new init, then raises it again. Expect no RESP until the new rising edge, and the new product is returned.
- **Reset mid-WAIT.** Assert `rst` during WAIT. Expect all outputs 0 asynchronously, state IDLE, `ptr`=0, and no `rsp_valid` from the aborted operation.
- **Timeout (macro defined, `TIMEOUT`=8).** Model never raises done. Expect `rsp_valid` 9 cycles after `gnt` with `rsp_err`=1 and `rsp_pp`=0.
- **Withdrawn request.** Requester 1 pulses `req` during WAIT but drops it before RESP. Expect `gnt`[1] never asserted.
